axbtb_write_scheduler: RTL and testbench

- Write-port scheduler for the banked approximate-branch BTB array; sits between IntEx branch-result write requests and the multi-bank BTB RAM write ports.
- Resolves same-cycle bank conflicts by deferring losers into an internal replay queue and replaying them on idle, non-conflicting ports.
- Owns the array initialisation/invalidate sweep after reset and on flush, so the BTB datapath module only issues raw requests.

---
 rtl/axbtb_write_scheduler_pkg.sv | 26 ++
 rtl/axbtb_write_scheduler_replay_queue.sv | 43 ++++
 rtl/axbtb_write_scheduler.sv | 165 ++++++++++++++++
 tb/tb_axbtb_write_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/axbtb_write_scheduler_pkg.sv
// Shared fetch-unit types for the approximate-branch BTB.
// Write request bundle, scheduler states and bank extraction.
package FetchUnitTypes;

  localparam int AXBTB_ENTRY_NUM = 1024;
  localparam int AXBTB_IDX_W     = $clog2(AXBTB_ENTRY_NUM);
  localparam int AXBTB_ENTRY_W   = 32;

  typedef logic [0:0] AXBTB_SchedState;
  localparam AXBTB_SchedState INIT = 1'b0;
  localparam AXBTB_SchedState RUN  = 1'b1;

  typedef struct packed {
    logic [AXBTB_IDX_W-1:0]   idx;
    logic [AXBTB_ENTRY_W-1:0] data;
  } AXBTB_WriteReq;

  // bankNum is a power of two, so the bank is the low index bits
  function automatic int unsigned axbtbBank(
    input logic [31:0] idx,
    input int unsigned bankNum
  );
    return idx & (bankNum - 1);
  endfunction

endpackage

// File: rtl/axbtb_write_scheduler_replay_queue.sv
// Circular replay FIFO for bank-conflict losers.
// Pointers carry an extra MSB so count separates full from empty.
module axbtb_replay_queue #(
  parameter int W     = 42,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  pushData,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [AW:0]   count
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  hPtr;
  logic [AW:0]  tPtr;

  assign head  = mem[hPtr[AW-1:0]];
  assign count = tPtr - hPtr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hPtr <= '0;
      tPtr <= '0;
    end else if (clear) begin
      hPtr <= '0;
      tPtr <= '0;
    end else begin
      if (push) tPtr <= tPtr + 1'b1;
      if (pop)  hPtr <= hPtr + 1'b1;
    end
  end

  // full push with a same-cycle pop lands in the slot being vacated
  always_ff @(posedge clk) begin
    if (push && !clear) mem[tPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/axbtb_write_scheduler.sv
// BTB write-port scheduler: bank arbitration, replay and init sweep.
// Lower ports win their bank; one loser per cycle goes to replay.
module axbtb_write_scheduler
  import FetchUnitTypes::*;
#(
  parameter int WRITE_NUM  = 2,
  parameter int ENTRY_NUM  = AXBTB_ENTRY_NUM,
  parameter int BANK_NUM   = 2,
  parameter int ENTRY_W    = AXBTB_ENTRY_W,
  parameter int QUEUE_SIZE = 8,
  localparam int IDX_W     = $clog2(ENTRY_NUM),
  localparam int CNT_W     = $clog2(QUEUE_SIZE) + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flushReq,
  input  logic [WRITE_NUM-1:0]               reqValid,
  input  logic [WRITE_NUM-1:0][IDX_W-1:0]    reqIdx,
  input  logic [WRITE_NUM-1:0][ENTRY_W-1:0]  reqData,
  output logic [WRITE_NUM-1:0]               we,
  output logic [WRITE_NUM-1:0][IDX_W-1:0]    wa,
  output logic [WRITE_NUM-1:0][ENTRY_W-1:0]  wv,
  output logic                               busy,
  output logic [CNT_W-1:0]                   qCount,
  output logic [15:0]                        dropCnt
);

  localparam int BW = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
  localparam int QW = IDX_W + ENTRY_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRY_NUM - 1);
  localparam logic [CNT_W-1:0] QFULL = CNT_W'(QUEUE_SIZE);

  AXBTB_SchedState state;
  logic [IDX_W-1:0] sweepIdx;

  logic [WRITE_NUM-1:0][BW-1:0] reqBank;
  logic [QW-1:0]      qHead;
  logic [IDX_W-1:0]   headIdx;
  logic [BW-1:0]      headBank;
  logic               qEmpty;
  logic               qFull;

  logic [WRITE_NUM-1:0]              weN;
  logic [WRITE_NUM-1:0][IDX_W-1:0]   waN;
  logic [WRITE_NUM-1:0][ENTRY_W-1:0] wvN;
  logic [BANK_NUM-1:0]  bankUsed;
  logic [WRITE_NUM-1:0] granted;
  logic                 loserSeen;
  logic                 pushEn;
  logic [QW-1:0]        pushData;
  logic                 popEn;
  logic [15:0]          dropInc;
  logic [16:0]          dropSum;

  always_comb begin
    for (int i = 0; i < WRITE_NUM; i++) begin
      reqBank[i] = BW'(axbtbBank(32'(reqIdx[i]), BANK_NUM));
    end
  end

  assign headIdx  = qHead[QW-1:ENTRY_W];
  assign headBank = BW'(axbtbBank(32'(headIdx), BANK_NUM));
  assign qEmpty   = (qCount == '0);
  assign qFull    = (qCount == QFULL);

  always_comb begin
    weN       = '0;
    waN       = '0;
    wvN       = '0;
    bankUsed  = '0;
    granted   = '0;
    loserSeen = 1'b0;
    pushEn    = 1'b0;
    pushData  = '0;
    popEn     = 1'b0;
    dropInc   = '0;
    if (state == INIT || flushReq) begin
      for (int i = 0; i < WRITE_NUM; i++) begin
        dropInc += 16'(reqValid[i]);
      end
      if (state == RUN) dropInc += 16'(qCount);
      if (state == INIT && !flushReq) begin
        weN[0] = 1'b1;
        waN[0] = sweepIdx;
      end
    end else begin
      for (int i = 0; i < WRITE_NUM; i++) begin
        if (reqValid[i]) begin
          if (!bankUsed[reqBank[i]]) begin
            bankUsed[reqBank[i]] = 1'b1;
            granted[i] = 1'b1;
            weN[i]     = 1'b1;
            waN[i]     = reqIdx[i];
            wvN[i]     = reqData[i];
          end else if (!loserSeen) begin
            loserSeen = 1'b1;
            pushData  = {reqIdx[i], reqData[i]};
          end else begin
            dropInc += 16'd1;
          end
        end
      end
      // replay only on a free port whose bank no new write claimed
      if (!qEmpty && !bankUsed[headBank]) begin
        for (int i = 0; i < WRITE_NUM; i++) begin
          if (!granted[i] && !popEn) begin
            popEn  = 1'b1;
            weN[i] = 1'b1;
            waN[i] = headIdx;
            wvN[i] = qHead[ENTRY_W-1:0];
          end
        end
      end
      if (loserSeen) begin
        if (!qFull || popEn) pushEn = 1'b1;
        else dropInc += 16'd1;
      end
    end
  end

  assign dropSum = {1'b0, dropCnt} + {1'b0, dropInc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      sweepIdx <= '0;
      busy     <= 1'b1;
      we       <= '0;
      wa       <= '0;
      wv       <= '0;
      dropCnt  <= '0;
    end else begin
      we      <= weN;
      wa      <= waN;
      wv      <= wvN;
      dropCnt <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
      if (flushReq) begin
        state    <= INIT;
        sweepIdx <= '0;
        busy     <= 1'b1;
      end else if (state == INIT) begin
        sweepIdx <= sweepIdx + 1'b1;
        if (sweepIdx == LAST) begin
          state <= RUN;
          busy  <= 1'b0;
        end
      end
    end
  end

  axbtb_replay_queue #(
    .W     (QW),
    .DEPTH (QUEUE_SIZE)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .clear    (flushReq || state == INIT),
    .push     (pushEn),
    .pushData (pushData),
    .pop      (popEn),
    .head     (qHead),
    .count    (qCount)
  );

endmodule

// File: tb/tb_axbtb_write_scheduler.sv
// Directed bench for axbtb_write_scheduler.
// Expected writes are queued on drive and popped when outputs appear.
module tb_axbtb_write_scheduler;
  import FetchUnitTypes::*;

  logic            clk;
  logic            rst;
  logic            flushReq;
  logic [1:0]      reqValid;
  logic [1:0][9:0] reqIdx;
  logic [1:0][31:0] reqData;
  logic [1:0]      we;
  logic [1:0][9:0] wa;
  logic [1:0][31:0] wv;
  logic            busy;
  logic [3:0]      qCount;
  logic [15:0]     dropCnt;

  typedef struct {
    int            port;
    AXBTB_WriteReq w;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] shadow [1024];
  int          nAsserts = 0;
  int          nFail    = 0;

  axbtb_write_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .flushReq (flushReq),
    .reqValid (reqValid),
    .reqIdx   (reqIdx),
    .reqData  (reqData),
    .we       (we),
    .wa       (wa),
    .wv       (wv),
    .busy     (busy),
    .qCount   (qCount),
    .dropCnt  (dropCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expW(input int port, input logic [9:0] idx,
                      input logic [31:0] d);
    exp_t e;
    e.port   = port;
    e.w.idx  = idx;
    e.w.data = d;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic v0, input logic [9:0] i0,
                     input logic [31:0] d0, input logic v1,
                     input logic [9:0] i1, input logic [31:0] d1,
                     input logic fl);
    reqValid   = {v1, v0};
    reqIdx[0]  = i0;
    reqIdx[1]  = i1;
    reqData[0] = d0;
    reqData[1] = d1;
    flushReq   = fl;
    @(posedge clk);
    #1;
    reqValid = '0;
    flushReq = 1'b0;
  endtask

  task automatic checkOut(input string tag);
    logic [1:0] expWe;
    exp_t       e;
    expWe = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      expWe[e.port] = 1'b1;
      chk({tag, "_wa"}, 64'(wa[e.port]), 64'(e.w.idx));
      chk({tag, "_wv"}, 64'(wv[e.port]), 64'(e.w.data));
    end
    chk({tag, "_we"}, 64'(we), 64'(expWe));
    for (int p = 0; p < 2; p++) begin
      if (we[p]) shadow[wa[p]] = wv[p];
    end
  endtask

  task automatic sweepCheck(input int reqAt);
    for (int k = 0; k < 1024; k++) begin
      if (k == reqAt) cyc(1, 10'd3, 32'h1, 1, 10'd5, 32'h2, 0);
      else cyc(0, 0, 0, 0, 0, 0, 0);
      chk("sweep_we", 64'(we), 64'd1);
      chk("sweep_wa", 64'(wa[0]), 64'(k));
      chk("sweep_wv", 64'(wv[0]), 64'd0);
      chk("sweep_busy", 64'(busy), 64'(k != 1023));
    end
  endtask

  initial begin
    rst      = 1'b0;
    flushReq = 1'b0;
    reqValid = '0;
    reqIdx   = '0;
    reqData  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_wa", 64'(wa), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_q", 64'(qCount), 64'd0);
    chk("rst_drop", 64'(dropCnt), 64'd0);
    rst = 1'b1;

    sweepCheck(-1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    checkOut("post_sweep");
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_drop", 64'(dropCnt), 64'd0);

    expW(0, 10'd4, 32'hAAAA0004);
    expW(1, 10'd7, 32'hBBBB0007);
    cyc(1, 10'd4, 32'hAAAA0004, 1, 10'd7, 32'hBBBB0007, 0);
    checkOut("nocfl");
    chk("nocfl_q", 64'(qCount), 64'd0);

    expW(0, 10'd4, 32'hC0000004);
    cyc(1, 10'd4, 32'hC0000004, 1, 10'd6, 32'hC0000006, 0);
    checkOut("cfl");
    chk("cfl_q", 64'(qCount), 64'd1);
    expW(0, 10'd6, 32'hC0000006);
    cyc(0, 0, 0, 0, 0, 0, 0);
    checkOut("replay");
    chk("replay_q", 64'(qCount), 64'd0);

    for (int k = 0; k < 8; k++) begin
      expW(0, 10'd4, 32'h100 + k);
      cyc(1, 10'd4, 32'h100 + k, 1, 10'(20 + 2 * k), 32'h200 + k, 0);
      checkOut("fill");
      chk("fill_q", 64'(qCount), 64'(k + 1));
    end
    expW(0, 10'd4, 32'h108);
    cyc(1, 10'd4, 32'h108, 1, 10'd40, 32'h999, 0);
    checkOut("full");
    chk("full_q", 64'(qCount), 64'd8);
    chk("full_drop", 64'(dropCnt), 64'd1);
    for (int k = 0; k < 8; k++) begin
      expW(0, 10'(20 + 2 * k), 32'h200 + k);
      cyc(0, 0, 0, 0, 0, 0, 0);
      checkOut("drain");
      chk("drain_q", 64'(qCount), 64'(7 - k));
    end

    expW(0, 10'd10, 32'hA);
    cyc(1, 10'd10, 32'hA, 1, 10'd10, 32'hB, 0);
    checkOut("same_a");
    expW(0, 10'd10, 32'hB);
    cyc(0, 0, 0, 0, 0, 0, 0);
    checkOut("same_b");
    chk("same_final", 64'(shadow[10]), 64'hB);

    for (int k = 0; k < 3; k++) begin
      expW(0, 10'd4, 32'h300 + k);
      cyc(1, 10'd4, 32'h300 + k, 1, 10'(30 + 2 * k), 32'h400 + k, 0);
      checkOut("pre_flush");
    end
    chk("pre_flush_q", 64'(qCount), 64'd3);
    cyc(1, 10'd8, 32'h500, 0, 0, 0, 1);
    checkOut("flush");
    chk("flush_busy", 64'(busy), 64'd1);
    chk("flush_q", 64'(qCount), 64'd0);
    chk("flush_drop", 64'(dropCnt), 64'd5);
    sweepCheck(5);
    chk("sweep2_drop", 64'(dropCnt), 64'd7);
    cyc(0, 0, 0, 0, 0, 0, 0);
    checkOut("post_sweep2");

    for (int k = 0; k < 2; k++) begin
      expW(0, 10'd4, 32'h600 + k);
      cyc(1, 10'd4, 32'h600 + k, 1, 10'(50 + 2 * k), 32'h700 + k, 0);
      checkOut("pre_arst");
    end
    chk("pre_arst_q", 64'(qCount), 64'd2);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_we", 64'(we), 64'd0);
    chk("arst_q", 64'(qCount), 64'd0);
    chk("arst_busy", 64'(busy), 64'd1);
    chk("arst_drop", 64'(dropCnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAsserts, nFail);
    $finish;
  end

endmodule
